// File: rtl/id_ctrl_pkg.sv
// Shared definitions for the ID-stage control decoder: opcodes, ALUOp codes,
// the ID/EX control bundle and the issue FSM states.
package id_ctrl_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned ALUOP_W = 3;
    localparam int unsigned RA_W    = 5;

    localparam logic [OP_W-1:0] OP_R    = 6'b000000;
    localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;
    localparam logic [OP_W-1:0] OP_LW   = 6'b101100;
    localparam logic [OP_W-1:0] OP_SW   = 6'b101101;
    localparam logic [OP_W-1:0] OP_BEQ  = 6'b001010;
    localparam logic [OP_W-1:0] OP_BNE  = 6'b001011;
    localparam logic [OP_W-1:0] OP_J    = 6'b000010;
    localparam logic [OP_W-1:0] OP_JAL  = 6'b000011;
    localparam logic [OP_W-1:0] OP_BLT  = 6'b001110;
    localparam logic [OP_W-1:0] OP_BNEZ = 6'b001100;
    localparam logic [OP_W-1:0] OP_BGEZ = 6'b001101;

    localparam logic [ALUOP_W-1:0] ALU_MEM  = 3'b000;
    localparam logic [ALUOP_W-1:0] ALU_BEQ  = 3'b001;
    localparam logic [ALUOP_W-1:0] ALU_R    = 3'b010;
    localparam logic [ALUOP_W-1:0] ALU_ADDI = 3'b011;
    localparam logic [ALUOP_W-1:0] ALU_BLT  = 3'b100;
    localparam logic [ALUOP_W-1:0] ALU_BGEZ = 3'b101;
    localparam logic [ALUOP_W-1:0] ALU_BNE  = 3'b110;

    typedef struct packed {
        logic               reg_write;
        logic [ALUOP_W-1:0] alu_op;
        logic               alu_src;
        logic               reg_dst;
        logic               branch;
        logic               mem_read;
        logic               mem_write;
        logic               mem_to_reg;
        logic               jump;
        logic               branch_type;
        logic               jal;
        logic               rt_sel;
    } ctrl_t;

    typedef enum logic [0:0] {RUN, SHADOW} state_e;

    // Branches and jumps open the issue shadow.
    function automatic logic is_redirect(input ctrl_t c);
        return c.branch | c.jump;
    endfunction

endpackage

// File: rtl/id_ctrl_lut.sv
// Pure combinational opcode to control-bundle lookup; legal_o flags known opcodes.
module id_ctrl_lut
    import id_ctrl_pkg::*;
(
    input  logic [OP_W-1:0] op_i,
    output ctrl_t           ctrl_o,
    output logic            legal_o
);

    always_comb begin
        ctrl_o  = '0;
        legal_o = 1'b1;
        case (op_i)
            OP_R: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_op    = ALU_R;
                ctrl_o.reg_dst   = 1'b1;
            end
            OP_ADDI: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_op    = ALU_ADDI;
                ctrl_o.alu_src   = 1'b1;
            end
            OP_LW: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.alu_op     = ALU_MEM;
                ctrl_o.alu_src    = 1'b1;
                ctrl_o.mem_read   = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            OP_SW: begin
                ctrl_o.alu_op    = ALU_MEM;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.mem_write = 1'b1;
            end
            OP_BEQ: begin
                ctrl_o.branch = 1'b1;
                ctrl_o.alu_op = ALU_BEQ;
            end
            OP_BNE: begin
                ctrl_o.branch      = 1'b1;
                ctrl_o.alu_op      = ALU_BNE;
                ctrl_o.branch_type = 1'b1;
            end
            OP_BLT: begin
                ctrl_o.branch      = 1'b1;
                ctrl_o.alu_op      = ALU_BLT;
                ctrl_o.branch_type = 1'b1;
            end
            OP_BNEZ: begin
                ctrl_o.branch      = 1'b1;
                ctrl_o.alu_op      = ALU_BNE;
                ctrl_o.branch_type = 1'b1;
                ctrl_o.rt_sel      = 1'b1;
            end
            OP_BGEZ: begin
                ctrl_o.branch = 1'b1;
                ctrl_o.alu_op = ALU_BGEZ;
                ctrl_o.rt_sel = 1'b1;
            end
            OP_J: begin
                ctrl_o.jump = 1'b1;
            end
            // jal writes the link register
            OP_JAL: begin
                ctrl_o.jump      = 1'b1;
                ctrl_o.jal       = 1'b1;
                ctrl_o.reg_write = 1'b1;
            end
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/id_ctrl_stage.sv
// ID/EX control register with ready/valid flow control, load-use stall,
// branch/jump issue shadow, flush and a saturating stall counter.
module id_ctrl_stage
    import id_ctrl_pkg::*;
#(
    parameter int unsigned BR_SHADOW = 2,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [OP_W-1:0]  op_i,
    input  logic [RA_W-1:0]  rs_i,
    input  logic [RA_W-1:0]  rt_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output ctrl_t            ctrl_o,
    output logic [RA_W-1:0]  wr_rt_o,
    input  logic             flush_i,
    input  logic             br_resolve_i,
    output logic             illegal_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int unsigned SH_W = $clog2(BR_SHADOW + 1);

    state_e            state_q, state_d;
    logic [SH_W-1:0]   shadow_q, shadow_d;
    logic              valid_q, valid_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic [RA_W-1:0]   wr_rt_q, wr_rt_d;
    logic              illegal_q, illegal_d;
    logic [CNT_W-1:0]  stall_q, stall_d;

    ctrl_t             lut_ctrl;
    logic              lut_legal;
    logic              hazard_c, ready_c, accept_c, hold_c;

    id_ctrl_lut u_lut (
        .op_i    (op_i),
        .ctrl_o  (lut_ctrl),
        .legal_o (lut_legal)
    );

    // Load-use: the lw sitting in ID/EX targets a source of the instruction in ID.
    assign hazard_c = valid_q && ctrl_q.mem_read && (wr_rt_q != '0) &&
                      ((wr_rt_q == rs_i) || (wr_rt_q == rt_i));
    assign hold_c   = valid_q && !out_ready_i;
    assign ready_c  = (state_q == RUN) && !flush_i && !hazard_c && !hold_c;
    assign accept_c = in_valid_i && ready_c;

    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        valid_d   = valid_q;
        ctrl_d    = ctrl_q;
        wr_rt_d   = wr_rt_q;
        illegal_d = 1'b0;
        stall_d   = stall_q;

        if (in_valid_i && !ready_c && !flush_i && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end

        if (flush_i) begin
            valid_d  = 1'b0;
            ctrl_d   = '0;
            wr_rt_d  = '0;
            state_d  = RUN;
            shadow_d = '0;
        end else begin
            if (hold_c) begin
                illegal_d = illegal_q;
            end else if (accept_c && lut_legal) begin
                valid_d = 1'b1;
                ctrl_d  = lut_ctrl;
                wr_rt_d = rt_i;
            end else begin
                valid_d   = 1'b0;
                ctrl_d    = '0;
                wr_rt_d   = '0;
                illegal_d = accept_c;
            end

            case (state_q)
                RUN: begin
                    if (accept_c && lut_legal && is_redirect(lut_ctrl)) begin
                        state_d  = SHADOW;
                        shadow_d = SH_W'(BR_SHADOW);
                    end
                end
                SHADOW: begin
                    if (br_resolve_i || (shadow_q <= SH_W'(1))) begin
                        state_d  = RUN;
                        shadow_d = '0;
                    end else begin
                        shadow_d = shadow_q - SH_W'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= RUN;
            shadow_q  <= '0;
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            wr_rt_q   <= '0;
            illegal_q <= 1'b0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
            wr_rt_q   <= wr_rt_d;
            illegal_q <= illegal_d;
            stall_q   <= stall_d;
        end
    end

    assign in_ready_o  = ready_c;
    assign out_valid_o = valid_q;
    assign ctrl_o      = ctrl_q;
    assign wr_rt_o     = wr_rt_q;
    assign illegal_o   = illegal_q;
    assign stall_cnt_o = stall_q;

endmodule
